led_scan_ctrl: RTL

Scan controller for the LED dimmer. It sequences the shared 4-to-1 duty multiplexer across four LED channels and time-multiplexes one PWM comparator over them. For each channel it drives the mux `select`, latches the 4-bit duty that comes back, and generates a PWM-gated, active-low channel enable. It sits between the four channel duty registers (through the mux) and the LED anode drivers.

---
 rtl/led_scan_ctrl_if.sv | 19 +
 rtl/led_scan_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/led_scan_ctrl_if.sv
// rtl/led_scan_ctrl_if.sv - mux/anode bundle between the duty mux, scan controller and LED drivers
interface led_scan_ctrl_if;
  logic       enable;
  logic [3:0] duty_sel;
  logic [1:0] select;
  logic [3:0] an;
  logic       pwm_out;
  logic       frame_tick;

  modport master (
    output enable, duty_sel,
    input  select, an, pwm_out, frame_tick
  );

  modport slave (
    input  enable, duty_sel,
    output select, an, pwm_out, frame_tick
  );
endinterface

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - four-channel LED scan sequencer sharing one PWM comparator
module led_scan_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  led_scan_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_slot, w_slot_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [3:0]    r_pwm_cnt, w_pwm_cnt_nxt;
  logic [3:0]    r_duty_q, w_duty_q_nxt;
  logic [3:0]    r_an, w_an_nxt;
  logic          r_pwm_out, r_frame_tick;
  logic          w_frame_nxt, w_lit, w_step;

  always_comb begin
    w_state_nxt   = r_state;
    w_slot_nxt    = r_slot;
    w_presc_nxt   = r_presc;
    w_pwm_cnt_nxt = r_pwm_cnt;
    w_duty_q_nxt  = r_duty_q;
    w_frame_nxt   = 1'b0;
    w_step        = (r_presc == PRESC_MAX);
    w_lit         = (r_state == RUN) && (r_pwm_cnt < r_duty_q);
    w_an_nxt      = w_lit ? ~(4'b0001 << r_slot) : 4'b1111;

    case (r_state)
      IDLE: begin
        w_presc_nxt   = '0;
        w_pwm_cnt_nxt = 4'd0;
        w_slot_nxt    = 2'd0;
        if (bus.enable) w_state_nxt = LOAD;
      end
      LOAD: begin
        // select has been stable a full cycle, so the mux output is settled here
        w_duty_q_nxt  = bus.duty_sel;
        w_presc_nxt   = '0;
        w_pwm_cnt_nxt = 4'd0;
        w_state_nxt   = RUN;
      end
      RUN: begin
        if (w_step) begin
          w_presc_nxt = '0;
          if (r_pwm_cnt == 4'd14) begin
            w_pwm_cnt_nxt = 4'd0;
            w_slot_nxt    = r_slot + 2'd1;
            w_state_nxt   = LOAD;
            w_frame_nxt   = (r_slot == 2'd3);
          end else begin
            w_pwm_cnt_nxt = r_pwm_cnt + 4'd1;
          end
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Disable parks everything so a re-enable always restarts at slot 0
    if (!bus.enable) begin
      w_state_nxt   = IDLE;
      w_slot_nxt    = 2'd0;
      w_presc_nxt   = '0;
      w_pwm_cnt_nxt = 4'd0;
      w_frame_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_slot       <= 2'd0;
      r_presc      <= '0;
      r_pwm_cnt    <= 4'd0;
      r_duty_q     <= 4'd0;
      r_an         <= 4'b1111;
      r_pwm_out    <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_presc      <= w_presc_nxt;
      r_pwm_cnt    <= w_pwm_cnt_nxt;
      r_duty_q     <= w_duty_q_nxt;
      r_an         <= w_an_nxt;
      r_pwm_out    <= w_lit;
      r_frame_tick <= w_frame_nxt;
    end
  end

  assign bus.select     = r_slot;
  assign bus.an         = r_an;
  assign bus.pwm_out    = r_pwm_out;
  assign bus.frame_tick = r_frame_tick;

endmodule
